instr_fetch_stream: RTL and testbench



---
 rtl/instr_fetch_stream.sv | 137 +++++++++++++
 tb/tb_instr_fetch_stream.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stream.sv
// Instruction fetch stage: one outstanding imem request, redirect with stale-response
// drop, and a one-entry skid buffer in front of the registered IF/ID output.
module instr_fetch_stream #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic              pc_source,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [DATA_W-1:0] instruction
);

    // state   | meaning
    // S_FETCH | idle, issue a request once the output can take data
    // S_WAIT  | one request outstanding, response will be used
    // S_DROP  | one request outstanding, response is stale and discarded
    // S_HOLD  | response parked in skid buffer, waiting for stall to drop
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_inc;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic              can_load;

    assign fetch_pc_inc = fetch_pc + PC_STEP;
    assign branch_pc    = pc_branch & ALIGN_MASK;
    assign can_load     = !if_valid || !stall;

    // A response in S_WAIT with decode running lets the next request go out in the same cycle.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (!reset && !pc_source) begin
            case (state)
                S_FETCH: imem_req = can_load;
                S_WAIT: begin
                    if (imem_ready && !stall) begin
                        imem_req  = 1'b1;
                        imem_addr = fetch_pc_inc;
                    end
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            fetch_pc    <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            pc_next     <= '0;
            instruction <= '0;
            skid_pc     <= '0;
            skid_data   <= '0;
        end else if (pc_source) begin
            fetch_pc <= branch_pc;
            if_valid <= 1'b0;
            // An in-flight request that has not answered yet must be drained before refetching.
            if ((state == S_WAIT || state == S_DROP) && !imem_ready) begin
                state <= S_DROP;
            end else begin
                state <= S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                    end
                    if (can_load) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ready && can_load) begin
                        if_valid    <= 1'b1;
                        if_pc       <= fetch_pc;
                        pc_next     <= fetch_pc_inc;
                        instruction <= imem_rdata;
                        fetch_pc    <= fetch_pc_inc;
                        state       <= stall ? S_FETCH : S_WAIT;
                    end else if (imem_ready) begin
                        skid_pc   <= fetch_pc;
                        skid_data <= imem_rdata;
                        fetch_pc  <= fetch_pc_inc;
                        state     <= S_HOLD;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    // fetch_pc already points one word past the parked instruction.
                    if (!stall) begin
                        if_valid    <= 1'b1;
                        if_pc       <= skid_pc;
                        pc_next     <= fetch_pc;
                        instruction <= skid_data;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stream.sv
// Bench for instr_fetch_stream: variable-latency memory model plus an instruction-stream
// scoreboard (consumed PCs run sequentially from reset or the latest redirect target).
module tb_instr_fetch_stream;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] pc_branch  = '0;
    logic        pc_source  = 1'b0;
    logic        stall      = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] pc_next;
    logic [31:0] instruction;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          consumed = 0;
    logic [31:0] exp_pc = RST_PC;
    logic        redir_prev = 1'b0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    instr_fetch_stream #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_branch  (pc_branch),
        .pc_source  (pc_source),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .pc_next    (pc_next),
        .instruction(instruction)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard checks at negedge, memory model update after posedge.
    task automatic tick();
        logic        req_s, rdy_s;
        logic [31:0] addr_s, e4;
        @(negedge clk);
        req_s  = imem_req;
        addr_s = imem_addr;
        rdy_s  = imem_ready;
        cyc++;
        n_vec++;
        if (req_s && mem_busy && !rdy_s) begin
            n_err++;
            $display("FAIL outstanding cyc=%0d req addr=%h while %h still pending", cyc, addr_s, mem_addr);
        end
        if (pc_source) begin
            n_vec++;
            if (req_s !== 1'b0) begin
                n_err++;
                $display("FAIL redirect_req cyc=%0d got imem_req=%b want 0", cyc, req_s);
            end
        end
        if (redir_prev) begin
            n_vec++;
            if (if_valid !== 1'b0) begin
                n_err++;
                $display("FAIL redirect_flush cyc=%0d got if_valid=%b want 0", cyc, if_valid);
            end
        end
        if (if_valid === 1'b1 && !stall) begin
            e4 = exp_pc + 32'd4;
            n_vec++;
            if (if_pc !== exp_pc || instruction !== (exp_pc ^ KEY) || pc_next !== e4) begin
                n_err++;
                $display("FAIL stream cyc=%0d got pc=%h instr=%h next=%h want pc=%h instr=%h next=%h",
                         cyc, if_pc, instruction, pc_next, exp_pc, exp_pc ^ KEY, e4);
            end
            exp_pc = e4;
            consumed++;
        end
        if (pc_source) exp_pc = pc_branch & 32'hFFFF_FFFC;
        redir_prev = pc_source;
        @(posedge clk);
        #1;
        if (rdy_s) mem_busy = 1'b0;
        if (req_s) begin
            mem_busy = 1'b1;
            mem_addr = addr_s;
            mem_cnt  = int'($urandom_range(lat_min, lat_max));
        end
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ready = 1'b1;
                imem_rdata = mem_addr ^ KEY;
            end
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        stall      = 1'b0;
        pc_source  = 1'b0;
        pc_branch  = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        redir_prev = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_pc = RST_PC;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_vec++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || pc_next !== 32'h0 || instruction !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got req=%b valid=%b pc=%h next=%h instr=%h want all 0",
                     imem_req, if_valid, if_pc, pc_next, instruction);
        end
        do_reset();
        #2;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_req got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                     imem_req, imem_addr, if_valid, RST_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] want_addr, want_pc;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 8; k++) begin
            #2;
            want_addr = RST_PC + 32'(4 * k);
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== want_addr) begin
                n_err++;
                $display("FAIL stream_addr k=%0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, want_addr);
            end
            if (k >= 2) begin
                want_pc = RST_PC + 32'(4 * (k - 2));
                n_vec++;
                if (if_valid !== 1'b1 || if_pc !== want_pc || pc_next !== want_pc + 32'd4) begin
                    n_err++;
                    $display("FAIL stream_out k=%0d got valid=%b pc=%h next=%h want valid=1 pc=%h",
                             k, if_valid, if_pc, pc_next, want_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency3();
        int reqs, valids;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        reqs    = 0;
        valids  = 0;
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 12; k++) begin
            #2;
            if (imem_req === 1'b1) reqs++;
            if (if_valid === 1'b1) valids++;
            tick();
        end
        n_vec++;
        if (reqs != 4 || valids != 4) begin
            n_err++;
            $display("FAIL latency3_rate got reqs=%0d valids=%0d in 12 cycles want 4 and 4", reqs, valids);
        end
    endtask

    task automatic test_redirect_drop();
        logic        found;
        int          got;
        logic [31:0] want [2];
        want[0] = 32'h200;
        want[1] = 32'h204;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            #2;
            if (imem_req === 1'b1 && imem_addr === 32'h108) found = 1'b1;
            tick();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL drop_setup got no request to 108 want one within 20 cycles");
        end
        pc_source = 1'b1;
        pc_branch = 32'h0000_0203;
        tick();
        pc_source = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            #2;
            if (if_valid === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL drop_stale_visible got valid pc=%h want no output before target fetch", if_pc);
            end
            if (imem_req === 1'b1) begin
                found = 1'b1;
                n_vec++;
                if (imem_addr !== 32'h200) begin
                    n_err++;
                    $display("FAIL drop_target_req got addr=%h want 00000200", imem_addr);
                end
            end
            tick();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL drop_timeout got no request after redirect want one within 20 cycles");
        end
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            #2;
            if (if_valid === 1'b1) begin
                n_vec++;
                if (if_pc !== want[got]) begin
                    n_err++;
                    $display("FAIL drop_out%0d got pc=%h want %h", got, if_pc, want[got]);
                end
                got++;
            end
            tick();
        end
        n_vec++;
        if (got != 2) begin
            n_err++;
            $display("FAIL drop_out_timeout got %0d outputs want 2", got);
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 3; k++) tick();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== 32'h104 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL skid_hold k=%0d got valid=%b pc=%h req=%b want valid=1 pc=00000104 req=0",
                         k, if_valid, if_pc, imem_req);
            end
            tick();
        end
        stall = 1'b0;
        #2;
        n_vec++;
        if (if_pc !== 32'h104 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL skid_release got pc=%h req=%b want pc=00000104 req=0", if_pc, imem_req);
        end
        tick();
        #2;
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h108 || instruction !== (32'h108 ^ KEY) ||
            imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
            n_err++;
            $display("FAIL skid_drain got valid=%b pc=%h instr=%h req=%b addr=%h want 1 00000108 %h 1 0000010c",
                     if_valid, if_pc, instruction, imem_req, imem_addr, 32'h108 ^ KEY);
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_redirect_skid();
        logic found;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 3; k++) tick();
        stall = 1'b1;
        tick();
        pc_source = 1'b1;
        pc_branch = 32'h0000_0300;
        tick();
        pc_source = 1'b0;
        #2;
        n_vec++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL rskid_flush got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000300",
                     if_valid, imem_req, imem_addr);
        end
        tick();
        stall = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #2;
            if (if_valid === 1'b1) begin
                found = 1'b1;
                n_vec++;
                if (if_pc !== 32'h300 || instruction !== (32'h300 ^ KEY)) begin
                    n_err++;
                    $display("FAIL rskid_first got pc=%h instr=%h want 00000300 %h", if_pc, instruction, 32'h300 ^ KEY);
                end
            end
            tick();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL rskid_timeout got no output want target within 10 cycles");
        end
    endtask

    task automatic test_wrap();
        int          got;
        logic [31:0] want [4];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        want[3] = 32'h0000_0004;
        do_reset();
        lat_min   = 1;
        lat_max   = 1;
        pc_source = 1'b1;
        pc_branch = 32'hFFFF_FFF9;
        tick();
        pc_source = 1'b0;
        got       = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #2;
            if (if_valid === 1'b1) begin
                n_vec++;
                if (if_pc !== want[got] || pc_next !== want[got] + 32'd4) begin
                    n_err++;
                    $display("FAIL wrap_out%0d got pc=%h next=%h want pc=%h", got, if_pc, pc_next, want[got]);
                end
                got++;
            end
            tick();
        end
        n_vec++;
        if (got != 4) begin
            n_err++;
            $display("FAIL wrap_timeout got %0d outputs want 4", got);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic found;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 4; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || pc_next !== 32'h0 || instruction !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got req=%b valid=%b pc=%h next=%h instr=%h want all 0",
                     imem_req, if_valid, if_pc, pc_next, instruction);
        end
        tick();
        tick();
        reset      = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        exp_pc     = RST_PC;
        redir_prev = 1'b0;
        lat_min    = 1;
        lat_max    = 1;
        #2;
        n_vec++;
        if (imem_ready !== 1'b1 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL midreset_restart got ready=%b req=%b addr=%h want ready=1 req=1 addr=%h",
                     imem_ready, imem_req, imem_addr, RST_PC);
        end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            #2;
            if (if_valid === 1'b1) begin
                found = 1'b1;
                n_vec++;
                if (if_pc !== RST_PC || instruction !== (RST_PC ^ KEY)) begin
                    n_err++;
                    $display("FAIL midreset_first got pc=%h instr=%h want %h %h", if_pc, instruction, RST_PC, RST_PC ^ KEY);
                end
            end
        end
        tick();
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL midreset_timeout got no output want one within 10 cycles");
        end
    endtask

    task automatic test_random();
        int start;
        do_reset();
        lat_min = 1;
        lat_max = 4;
        start   = consumed;
        for (int c = 0; c < 1500; c++) begin
            stall     = ($urandom_range(0, 99) < 30);
            pc_source = ($urandom_range(0, 99) < 6);
            if (pc_source) begin
                if ($urandom_range(0, 3) == 0) pc_branch = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else                           pc_branch = $urandom;
            end
            tick();
        end
        stall     = 1'b0;
        pc_source = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        n_vec++;
        if (consumed - start < 50) begin
            n_err++;
            $display("FAIL random_progress got %0d instructions consumed want at least 50", consumed - start);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency3();
        test_redirect_drop();
        test_stall_skid();
        test_redirect_skid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
